accum_rr_scheduler: RTL
=======================

// Module: accum_rr_scheduler
// PURPOSE
//  Shares one 32-bit accumulator datapath between NREQ requesters using round-robin arbitration.
//  Each grant is sequenced through a 3-cycle IDLE -> LATCH -> ADD handshake.
//  Sits between the requesting sub-blocks and the LED/status logic; total[23:16] drives led.
//  A per-requester mask allows software to enable or disable individual requesters.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  DW    32  operand and accumulator width
// PORTS
//  CLK          in   1         clock, rising edge
//  RST          in   1         synchronous active-high reset
//  req          in   NREQ      request per requester; level, held until ack
//  req_value    in   NREQ*DW   operands; requester i uses bits [i*DW +: DW]
//  req_mask     in   NREQ      1 = requester i is eligible
//  clr          in   1         synchronous clear of total and ovf
//  ack          out  NREQ      one-hot, 1-cycle pulse: operand of requester i was captured
//  busy         out  1         high in LATCH and ADD
//  last_id      out  3         index of the most recently granted requester
//  total        out  DW        accumulated sum
//  ovf          out  1         sticky carry-out of total
//  led          out  8         total[23:16]
// BEHAVIOUR
//  Reset values: state=IDLE, ack=0, busy=0, last_id=0, total=0, ovf=0, rr pointer ptr=0.
//  Reset in any state aborts the operation; the latched operand is discarded.
//  FSM:
//   IDLE:  elig = req & req_mask.
//          If elig != 0: pick the first set bit searching from ptr upward, wrapping at NREQ-1 -> 0.
//          Latch opnd <= req_value[idx]; last_id <= idx; go to LATCH.
//          Otherwise stay in IDLE.
//   LATCH: ack[idx]=1 for exactly this cycle; busy=1; go to ADD.
//   ADD:   {c,total} <= total + opnd (DW-bit, wraps mod 2^DW).
//          ovf <= ovf | c; ptr <= (idx==NREQ-1) ? 0 : idx+1; busy=1; go to IDLE.
//  Timing:
//   - Request decided in IDLE at cycle t; ack visible in cycle t+1; total updated at edge end of t+2.
//   - Maximum throughput is one grant per 3 cycles.
//  Requester rule: drop req in the cycle after ack. req still high when FSM is back in IDLE (t+3) is a new request.
//  Changes in req, req_mask or req_value after the IDLE decision do not affect the op in flight.
//  clr:
//   - total <= 0 and ovf <= 0 in any state.
//   - If clr coincides with ADD: clear wins, that operand is dropped, but ptr still advances.
//   - clr does not alter FSM sequencing.
//  Masked requesters are never acked, regardless of req. An all-zero mask keeps the FSM in IDLE.
//  last_id holds its value between grants.
// TESTING
//  1. Single req[0], value=5 -> ack[0] pulse 1 cycle after request; total=5 three cycles after request; ovf=0.
//  2. req=4'b1111, values 1,2,3,4, each requester drops req after ack -> grant order 0,1,2,3; ack pulses 3 cycles apart; total=10.
//  3. req[1] and req[3] held continuously -> grants alternate 1,3,1,3; no starvation; busy low only for one IDLE cycle between grants.
//  4. total=32'hFFFF_FFF0, req[2] value=32'h20 -> total=32'h10, ovf=1; ovf stays 1 after another add of 1.
//  5. req_mask=4'b1101, req=4'b0010 -> no ack, FSM stays in IDLE; set mask bit 1 -> ack[1].
//  6. RST asserted during LATCH -> total unchanged at 0 with no add; clr during ADD with value 7 -> total=0, ovf=0, next grant goes to idx+1.

Source files
------------

// File: rtl/accum_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : accum_rr_scheduler
//  Purpose  : Shares one DW-bit accumulator between NREQ requesters using
//             round-robin arbitration. Every grant runs a fixed 3-cycle
//             IDLE -> LATCH -> ADD sequence. total[23:16] drives the LEDs.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK        in   1        clock, rising edge
//    RST        in   1        synchronous active-high reset
//    req        in   NREQ     level request per requester, held until ack
//    req_value  in   NREQ*DW  operands, requester i at [i*DW +: DW]
//    req_mask   in   NREQ     1 = requester i eligible for arbitration
//    clr        in   1        synchronous clear of total and ovf
//    ack        out  NREQ     one-hot 1-cycle pulse: operand captured
//    busy       out  1        high while in LATCH or ADD
//    last_id    out  3        index of the most recently granted requester
//    total      out  DW       accumulated sum (wraps mod 2^DW)
//    ovf        out  1        sticky carry-out of total
//    led        out  8        total[23:16]
// ============================================================================
module accum_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int DW   = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_value,
  input  logic [NREQ-1:0]      req_mask,
  input  logic                 clr,
  output logic [NREQ-1:0]      ack,
  output logic                 busy,
  output logic [2:0]           last_id,
  output logic [DW-1:0]        total,
  output logic                 ovf,
  output logic [7:0]           led
);

  // Index width; NREQ is limited to 2..8 so this never exceeds last_id.
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    ADD   = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    ptr;     // round-robin start point for the next search
  logic [IW-1:0]    idx;     // requester owning the operation in flight
  logic [DW-1:0]    opnd;    // operand captured at the IDLE decision

  logic [NREQ-1:0]  elig;
  logic [IW-1:0]    cand [NREQ];
  logic [NREQ-1:0]  hit;
  logic [DW-1:0]    values [NREQ];
  logic             found;
  logic [IW-1:0]    pick;
  logic [NREQ-1:0]  pick_onehot;
  logic [DW:0]      sum_ext;

  assign elig = req & req_mask;

  // Unpack the flat operand bus so the winner can be selected by index.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign values[gi] = req_value[gi*DW +: DW];
    end
  endgenerate

  // Candidate k is the requester k positions above ptr, wrapping at NREQ.
  // hit[k] flags that this candidate is eligible.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IW:0] raw;
      assign raw      = {1'b0, ptr} + (IW+1)'(gi);
      assign cand[gi] = (raw >= NREQ_W) ? IW'(raw - NREQ_W) : raw[IW-1:0];
      assign hit[gi]  = elig[cand[gi]];
    end
  endgenerate

  // The lowest k with a hit is the first eligible requester at or after ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && hit[k]) begin
        found = 1'b1;
        pick  = cand[k];
      end
    end
  end

  assign pick_onehot = NREQ'(1) << pick;

  // One extra bit captures the carry-out feeding the sticky ovf flag.
  assign sum_ext = {1'b0, total} + {1'b0, opnd};

  assign led = total[23:16];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      ack     <= '0;
      busy    <= 1'b0;
      last_id <= '0;
      total   <= '0;
      ovf     <= 1'b0;
      ptr     <= '0;
      idx     <= '0;
      opnd    <= '0;
    end else begin
      // ack is a single-cycle pulse, only ever set on the IDLE -> LATCH edge.
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            idx     <= pick;
            opnd    <= values[pick];
            last_id <= 3'(pick);
            ack     <= pick_onehot;
            busy    <= 1'b1;
            state   <= LATCH;
          end else begin
            busy    <= 1'b0;
          end
        end
        LATCH: begin
          busy  <= 1'b1;
          state <= ADD;
        end
        ADD: begin
          total <= sum_ext[DW-1:0];
          ovf   <= ovf | sum_ext[DW];
          // The pointer moves past the winner even if clr drops the add.
          ptr   <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      // Clear overrides any add in the same cycle but leaves sequencing alone.
      if (clr) begin
        total <= '0;
        ovf   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
